led_blink_ctrl: RTL

//   Parametrised multi-channel LED driver for the SmartFusion2 fabric: per-channel OFF/ON/BLINK/ONESHOT

---
 rtl/led_blink_pkg.sv | 21 ++
 rtl/led_blink_chan.sv | 96 +++++++++
 rtl/led_blink_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED driver: mode encodings,
// reset duty value and channel-select width helper.
// Optional PWM dimming is enabled with the LED_BLINK_PWM_EN macro.
package led_blink_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_BLINK   = 2'b10,
        LED_ONESHOT = 2'b11
    } led_mode_t;

    // Duty after reset: full brightness.
    localparam logic [3:0] DUTY_RST = 4'hF;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: config registers, tick counter and mode FSM.
// Produces the combinational "active" level (before polarity inversion)
// and a registered one-cycle completion flag for ONESHOT.
// With LED_BLINK_PWM_EN defined, a per-channel duty gates the active level.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr,
    input  led_mode_t        wr_mode,
    input  logic [CNT_W-1:0] wr_period,
    input  logic             wr_inv,
`ifdef LED_BLINK_PWM_EN
    input  logic [3:0]       wr_duty,
    input  logic [3:0]       pwm_cnt,
`endif
    output logic             active,
    output logic             inv,
    output logic             done
);

    led_mode_t        mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             at_end;
    logic             lit;

    assign at_end = (cnt == period);

    // Mode FSM: a write always restarts the channel, otherwise ticks advance
    // BLINK/ONESHOT. The counter stops at period so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= LED_OFF;
            period <= '0;
            inv    <= 1'b0;
            cnt    <= '0;
            phase  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr) begin
                mode   <= wr_mode;
                period <= wr_period;
                inv    <= wr_inv;
                cnt    <= '0;
                phase  <= 1'b1;
            end else if (tick) begin
                case (mode)
                    LED_BLINK: begin
                        if (at_end) begin
                            cnt   <= '0;
                            phase <= ~phase;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    LED_ONESHOT: begin
                        if (at_end) begin
                            mode  <= LED_OFF;
                            phase <= 1'b0;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lit = (mode == LED_ON) |
                 (((mode == LED_BLINK) | (mode == LED_ONESHOT)) & phase);

`ifdef LED_BLINK_PWM_EN
    logic [3:0] duty;

    // Duty is captured with every write to this channel.
    always_ff @(posedge clk) begin
        if (rst)     duty <= DUTY_RST;
        else if (wr) duty <= wr_duty;
    end

    assign active = lit & (pwm_cnt <= duty);
`else
    assign active = lit;
`endif

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver top: config write decode, per-channel instances,
// optional shared PWM counter and the registered led/done outputs.
// Config writes land in the channel at the first edge and show on led_o at
// the second. Define LED_BLINK_PWM_EN to add cfg_duty_i and PWM dimming.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 24,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [CNT_W-1:0]  cfg_period_i,
    input  logic              cfg_inv_i,
`ifdef LED_BLINK_PWM_EN
    input  logic [3:0]        cfg_duty_i,
`endif
    output logic [NUM_CH-1:0] led_o,
    output logic [NUM_CH-1:0] done_o
);

    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] inv;
    logic [NUM_CH-1:0] done;

`ifdef LED_BLINK_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase shared by all channels.
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 4'd0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Selects >= NUM_CH match no channel and are dropped.
        assign wr[i] = cfg_we_i && (int'(cfg_ch_i) == i);

        led_blink_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_i),
            .wr        (wr[i]),
            .wr_mode   (led_mode_t'(cfg_mode_i)),
            .wr_period (cfg_period_i),
            .wr_inv    (cfg_inv_i),
`ifdef LED_BLINK_PWM_EN
            .wr_duty   (cfg_duty_i),
            .pwm_cnt   (pwm_cnt),
`endif
            .active    (active[i]),
            .inv       (inv[i]),
            .done      (done[i])
        );
    end

    // Output stage: polarity applied after gating; done aligned with led drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_o  <= '0;
            done_o <= '0;
        end else begin
            led_o  <= active ^ inv;
            done_o <= done;
        end
    end

endmodule
